// File: rtl/nios_chave_pkg.sv
// nios_chave_pkg: shared constants and counter-width helper for the switch debouncer.
package nios_chave_pkg;
    localparam int CHAVE_WIDTH            = 4;
    localparam int CHAVE_DEBOUNCE_DEFAULT = 500000;

    // Counter width for a window of n cycles; a single-cycle window still needs one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [cnt_width(CHAVE_DEBOUNCE_DEFAULT)-1:0] cnt_t;
endpackage

// File: rtl/nios_chave_debounce_bit.sv
// nios_chave_debounce_bit: one switch line -- 2-flop synchronizer, bounce counter, accepted level.
// CHAVE_EDGE_EN builds registered rise/fall pulses; otherwise they are tied low.
module nios_chave_debounce_bit
    import nios_chave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CHAVE_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q, stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any disagreement short of the terminal count just advances; agreement clears the window.
    always_comb begin
        stable_d = (s2_q != stable_q && cnt_q == TERM) ? s2_q : stable_q;
        cnt_d    = (s2_q == stable_q || cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

`ifdef CHAVE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= stable_d & ~stable_q;
            fall_q <= ~stable_d & stable_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/nios_chave_debounce.sv
// nios_chave_debounce: debounced switch vector for the nios_chave PIO in_port.
// CHAVE_EDGE_EN enables per-bit chave_rise/chave_fall pulses (ports always present).
module nios_chave_debounce
    import nios_chave_pkg::*;
#(
    parameter int WIDTH           = CHAVE_WIDTH,
    parameter int DEBOUNCE_CYCLES = CHAVE_DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] chave_raw,
    output logic [WIDTH-1:0] chave_out,
    output logic [WIDTH-1:0] chave_rise,
    output logic [WIDTH-1:0] chave_fall
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_chave_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_i   (chave_raw[i]),
            .stable_o(chave_out[i]),
            .rise_o  (chave_rise[i]),
            .fall_o  (chave_fall[i])
        );
    end
endmodule

// File: tb/tb_nios_chave_debounce.sv
// tb_nios_chave_debounce: directed vectors with hand-computed expectations, DEBOUNCE_CYCLES=4.
module tb_nios_chave_debounce;
    localparam int W = 4;
`ifdef CHAVE_EDGE_EN
    localparam logic [W-1:0] EM = 4'hF;
`else
    localparam logic [W-1:0] EM = 4'h0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] chave_raw = 4'hF;
    logic [W-1:0] chave_out, chave_rise, chave_fall;
    int           n_chk = 0;
    int           n_pass = 0;

    nios_chave_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chave_raw (chave_raw),
        .chave_out (chave_out),
        .chave_rise(chave_rise),
        .chave_fall(chave_fall)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] o, input logic [W-1:0] r, input logic [W-1:0] f);
        chk({tag, ".out"}, chave_out, o);
        chk({tag, ".rise"}, chave_rise, r & EM);
        chk({tag, ".fall"}, chave_fall, f & EM);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // reset with switches held high
        ticks(3);
        chk_all("rst_hold", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        ticks(5);
        chk_all("rst_e4", 4'h0, 4'h0, 4'h0);
        ticks(1);
        chk_all("rst_e5", 4'hF, 4'hF, 4'h0);
        ticks(1);
        chk_all("rst_e6", 4'hF, 4'h0, 4'h0);
        // bit 0 falls then steps back up cleanly
        chave_raw = 4'hE;
        ticks(6);
        chk_all("fall0_e5", 4'hE, 4'h0, 4'h1);
        chave_raw = 4'hF;
        ticks(5);
        chk_all("step0_e4", 4'hE, 4'h0, 4'h0);
        ticks(1);
        chk_all("step0_e5", 4'hF, 4'h1, 4'h0);
        ticks(1);
        chk_all("step0_e6", 4'hF, 4'h0, 4'h0);
        // bit 1 low, then bounce 1,0,1,0 with 2-cycle periods, then hold 1
        chave_raw = 4'hD;
        ticks(6);
        chk_all("low1_e5", 4'hD, 4'h0, 4'h2);
        for (int k = 0; k < 4; k++) begin
            chave_raw = (k % 2 == 0) ? 4'hF : 4'hD;
            ticks(2);
            chk_all("bounce", 4'hD, 4'h0, 4'h0);
        end
        chave_raw = 4'hF;
        ticks(5);
        chk_all("bounce_e4", 4'hD, 4'h0, 4'h0);
        ticks(1);
        chk_all("bounce_e5", 4'hF, 4'h2, 4'h0);
        ticks(1);
        chk_all("bounce_e6", 4'hF, 4'h0, 4'h0);
        // bit 2 low, then a 3-cycle glitch high is rejected
        chave_raw = 4'hB;
        ticks(6);
        chk_all("low2_e5", 4'hB, 4'h0, 4'h4);
        chave_raw = 4'hF;
        ticks(3);
        chave_raw = 4'hB;
        for (int k = 0; k < 8; k++) begin
            ticks(1);
            chk_all("glitch", 4'hB, 4'h0, 4'h0);
        end
        // bits 3 and 0 fall together; bit 0 bounces once
        chave_raw = 4'h2;
        ticks(1);
        chave_raw = 4'h3;
        ticks(1);
        chave_raw = 4'h2;
        ticks(3);
        chk_all("simul_e4", 4'hB, 4'h0, 4'h0);
        ticks(1);
        chk_all("simul_e5", 4'h3, 4'h0, 4'h8);
        ticks(1);
        chk_all("simul_e6", 4'h3, 4'h0, 4'h0);
        ticks(1);
        chk_all("simul_e7", 4'h2, 4'h0, 4'h1);
        ticks(1);
        chk_all("simul_e8", 4'h2, 4'h0, 4'h0);
        // reset while the window sits at count 2
        chave_raw = 4'hF;
        ticks(4);
        chk_all("mid_e3", 4'h2, 4'h0, 4'h0);
        reset_n = 1'b0;
        #1;
        chk_all("mid_async", 4'h0, 4'h0, 4'h0);
        ticks(2);
        chk_all("mid_hold", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        ticks(5);
        chk_all("mid_e4", 4'h0, 4'h0, 4'h0);
        ticks(1);
        chk_all("mid_e5", 4'hF, 4'hF, 4'h0);
        ticks(1);
        chk_all("mid_e6", 4'hF, 4'h0, 4'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
